mod_counter: RTL and testbench

- Parametrised up/down counter; next generation of the team's 8-bit free-running counter.
- Adds:
  - configurable width and modulus
  - wrap or saturate mode
  - direction control, parallel load, synchronous clear, count enable
  - clock-enable prescaler
  - terminal-count pulse and sticky overflow flag
- Used as the general timebase/event counter in the lab designs. Drives displays and timers directly from `y`.

---
 rtl/counter_pkg.sv | 19 +
 rtl/clk_en_div.sv | 57 +++++
 rtl/mod_counter.sv | 100 ++++++++++
 tb/tb_mod_counter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_pkg
//  Description : Shared mode encodings and sizing helper for mod_counter.
//  Revision    : 1.0  initial release
// ============================================================================
package counter_pkg;

  // Boundary behaviour selected by the SAT parameter
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Width of a phase counter that must hold 0..div-1 (always at least 1 bit)
  function automatic int phase_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_en_div.sv
`default_nettype none
// ============================================================================
//  Module      : clk_en_div
//  Description : Clock-enable prescaler. Emits a one-cycle tick on every
//                DIV-th enabled cycle; en=0 freezes the phase.
//  Revision    : 1.0  initial release
// ============================================================================
module clk_en_div
  import counter_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic res,
  input  logic en,
  input  logic clr,
  output logic tick
);

  if (DIV < 1) begin : g_bad_div
    $error("clk_en_div: DIV must be >= 1");
  end else if (DIV == 1) begin : g_div1
    // No phase state at all: every enabled cycle is a tick
    logic w_unused;
    assign w_unused = &{1'b0, clk, res, clr};
    assign tick     = en;
  end else begin : g_div
    localparam int            PW     = phase_width(DIV);
    localparam logic [PW-1:0] C_LAST = PW'(DIV - 1);

    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_d;

    assign tick = en && (phase_q == C_LAST);

    // Next phase: restart on clear, advance (with wrap) only while enabled
    always_comb begin
      phase_d = phase_q;
      if (clr) begin
        phase_d = '0;
      end else if (en) begin
        phase_d = (phase_q == C_LAST) ? '0 : phase_q + 1'b1;
      end
    end

    // Phase register with synchronous reset
    always_ff @(posedge clk) begin
      if (res) begin
        phase_q <= '0;
      end else begin
        phase_q <= phase_d;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mod_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mod_counter
//  Description : Parametrised modulo up/down counter with wrap/saturate mode,
//                parallel load, synchronous clear, prescaled count enable,
//                terminal-count pulse and sticky overflow flag.
//  Revision    : 1.0  initial release
// ============================================================================
module mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int MODULO = 256,
  parameter int SAT    = 0,
  parameter int DIV    = 1
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] y,
  output logic             tc,
  output logic             ovf
);

  if (MODULO < 2 || longint'(MODULO) > (longint'(1) << WIDTH)) begin : g_bad_modulo
    $error("mod_counter: MODULO must satisfy 2 <= MODULO <= 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MODULO - 1);

  logic [WIDTH-1:0] y_q,   y_d;
  logic             tc_q,  tc_d;
  logic             ovf_q, ovf_d;
  logic             w_tick;

  // Load and clear both restart the prescaler so the next step is a full interval away
  clk_en_div #(
    .DIV (DIV)
  ) u_clk_en_div (
    .clk  (clk),
    .res  (res),
    .en   (en),
    .clr  (clr | load),
    .tick (w_tick)
  );

  // Next-state: load beats clear beats counting; boundary steps wrap or hold
  always_comb begin
    y_d   = y_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    if (load) begin
      y_d = (load_val > C_MAX) ? C_MAX : load_val;
    end else if (clr) begin
      y_d   = '0;
      ovf_d = 1'b0;
    end else if (w_tick) begin
      if (up) begin
        if (y_q >= C_MAX) begin
          tc_d  = 1'b1;
          ovf_d = 1'b1;
          y_d   = (SAT == MODE_SAT) ? y_q : '0;
        end else begin
          y_d = y_q + 1'b1;
        end
      end else begin
        if (y_q == '0) begin
          tc_d  = 1'b1;
          ovf_d = 1'b1;
          y_d   = (SAT == MODE_SAT) ? y_q : C_MAX;
        end else begin
          y_d = y_q - 1'b1;
        end
      end
    end
  end

  // Count, terminal-count and overflow registers with synchronous reset
  always_ff @(posedge clk) begin
    if (res) begin
      y_q   <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign y   = y_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mod_counter
//  Description : Scoreboard bench for mod_counter. Three instances (wrap/DIV1,
//                saturate/DIV1, wrap/DIV4, all MODULO=10) share one stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mod_counter;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       res = 1'b1, en = 1'b0, up = 1'b1, clr = 1'b0, load = 1'b0;
  logic [7:0] load_val = '0;

  logic [N-1:0][7:0] act_y;
  logic [N-1:0]      act_tc, act_ovf;

  mod_counter #(.WIDTH(8), .MODULO(10), .SAT(0), .DIV(1)) u_wrap (
    .clk(clk), .res(res), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .y(act_y[0]), .tc(act_tc[0]), .ovf(act_ovf[0]));

  mod_counter #(.WIDTH(8), .MODULO(10), .SAT(1), .DIV(1)) u_sat (
    .clk(clk), .res(res), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .y(act_y[1]), .tc(act_tc[1]), .ovf(act_ovf[1]));

  mod_counter #(.WIDTH(8), .MODULO(10), .SAT(0), .DIV(4)) u_div4 (
    .clk(clk), .res(res), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .y(act_y[2]), .tc(act_tc[2]), .ovf(act_ovf[2]));

  typedef struct packed {
    logic [N-1:0][7:0] y;
    logic [N-1:0]      tc;
    logic [N-1:0]      ovf;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference state per instance
  int m_y[N], m_ph[N], m_sat[N], m_div[N];
  bit m_tc[N], m_ovf[N];

  task automatic cmp(input string name, input int k, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d actual %0d required %0d", name, k, cyc, act, req);
    end
  endtask

  // Monitor: outputs are registered, so one expectation is due every cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      for (int k = 0; k < N; k++) begin
        cmp("y",   k, int'(act_y[k]),   int'(e.y[k]));
        cmp("tc",  k, int'(act_tc[k]),  int'(e.tc[k]));
        cmp("ovf", k, int'(act_ovf[k]), int'(e.ovf[k]));
      end
    end
  end

  // Advance the reference by one edge using the currently driven inputs
  task automatic model_edge();
    for (int k = 0; k < N; k++) begin
      bit tick;
      if (res) begin
        m_y[k] = 0; m_tc[k] = 0; m_ovf[k] = 0; m_ph[k] = 0;
      end else if (load) begin
        m_y[k] = (int'(load_val) >= 10) ? 9 : int'(load_val);
        m_tc[k] = 0; m_ph[k] = 0;
      end else if (clr) begin
        m_y[k] = 0; m_tc[k] = 0; m_ovf[k] = 0; m_ph[k] = 0;
      end else begin
        m_tc[k] = 0;
        tick = 0;
        if (en) begin
          if (m_ph[k] == m_div[k] - 1) begin
            tick = 1; m_ph[k] = 0;
          end else begin
            m_ph[k]++;
          end
        end
        if (tick) begin
          if (up && m_y[k] == 9) begin
            m_tc[k] = 1; m_ovf[k] = 1;
            if (m_sat[k] == 0) m_y[k] = 0;
          end else if (!up && m_y[k] == 0) begin
            m_tc[k] = 1; m_ovf[k] = 1;
            if (m_sat[k] == 0) m_y[k] = 9;
          end else begin
            m_y[k] = up ? m_y[k] + 1 : m_y[k] - 1;
          end
        end
      end
    end
  endtask

  // Drive one cycle of inputs, then queue the response expected after the edge
  task automatic step(input bit i_res, input bit i_en, input bit i_up,
                      input bit i_clr, input bit i_load, input int i_lv, input int n);
    for (int r = 0; r < n; r++) begin
      exp_t e;
      res = i_res; en = i_en; up = i_up; clr = i_clr; load = i_load;
      load_val = 8'(i_lv);
      model_edge();
      @(posedge clk);
      for (int k = 0; k < N; k++) begin
        e.y[k] = 8'(m_y[k]); e.tc[k] = m_tc[k]; e.ovf[k] = m_ovf[k];
      end
      exp_q.push_back(e);
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    m_sat = '{0, 1, 0};
    m_div = '{1, 1, 4};
    for (int k = 0; k < N; k++) begin
      m_y[k] = 0; m_ph[k] = 0; m_tc[k] = 0; m_ovf[k] = 0;
    end
    @(negedge clk);
    //            res en up clr ld  lv  n
    step(1, 0, 1, 0, 0,  0,  2);   // reset state
    step(0, 1, 1, 0, 0,  0, 11);   // 0..9 then wrap to 0 (tc, ovf)
    step(0, 0, 1, 1, 0,  0,  1);   // clear
    step(0, 1, 0, 0, 0,  0,  3);   // down: 0,9,8,7
    step(0, 0, 1, 1, 0,  0,  1);   // clear
    step(0, 1, 1, 0, 0,  0, 12);   // saturate at 9, repeated tc
    step(0, 0, 1, 1, 0,  0,  1);   // clear drops ovf
    step(0, 0, 1, 0, 1, 15,  1);   // load clamps to 9
    step(0, 1, 1, 1, 1,  3,  1);   // load beats en and clr
    step(0, 1, 1, 0, 0,  0,  6);   // DIV4 mid-phase
    step(0, 0, 1, 0, 0,  0,  3);   // en low freezes phase
    step(0, 1, 1, 0, 0,  0, 10);
    step(0, 1, 1, 1, 0,  0,  1);   // clear
    step(0, 1, 1, 0, 0,  0,  5);   // to y=5 in DIV1 instances
    step(1, 1, 1, 0, 0,  0,  1);   // mid-count reset
    step(0, 1, 1, 0, 0,  0,  9);   // resume with full DIV interval
    step(0, 1, 0, 0, 0,  0,  2);   // direction change
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual %0d required 0 pending", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
